// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game blocks: state encoding,
// LFSR taps and the clock-derived timing defaults.
package game_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned CLK_FREQ_HZ       = 100_000_000;
    localparam int unsigned DEFAULT_ON_CYCLES = CLK_FREQ_HZ;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; shared source of randomness for game events.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/target_ctrl.sv
// One whack-a-mole round per spawn pulse: light a random target, judge the
// player's press or the timeout, and keep saturating hit/miss tallies.
module target_ctrl
    import game_pkg::*;
#(
    parameter int          NUM_TARGETS = 8,
    parameter int unsigned ON_CYCLES   = DEFAULT_ON_CYCLES,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          SCORE_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   spawn,
    input  logic [NUM_TARGETS-1:0] btn,
    input  logic                   clr_score,
    output logic [NUM_TARGETS-1:0] led,
    output logic                   hit,
    output logic                   miss,
    output logic [SCORE_W-1:0]     hits,
    output logic [SCORE_W-1:0]     misses,
    output logic                   busy
);

    localparam int IDXW = $clog2(NUM_TARGETS);
    localparam int TW   = $clog2(ON_CYCLES);

    state_t                 state, state_n;
    logic [15:0]            lfsr;
    logic [IDXW-1:0]        prev_idx, prev_n, raw_idx, idx;
    logic [TW-1:0]          timer, timer_n;
    logic [NUM_TARGETS-1:0] btn_q, btn_rise, led_n;
    logic                   hit_n, miss_n;
    logic [SCORE_W-1:0]     hits_n, misses_n, hits_sat, misses_sat;
    logic                   unused_lfsr_bits;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign unused_lfsr_bits = ^lfsr[15:IDXW];

    // Never repeat the previous target: bump a collision to the next slot
    assign raw_idx = lfsr[IDXW-1:0];
    assign idx     = (raw_idx == prev_idx) ? raw_idx + IDXW'(1) : raw_idx;

    assign btn_rise   = btn & ~btn_q;
    assign hits_sat   = (&hits)   ? hits   : hits   + SCORE_W'(1);
    assign misses_sat = (&misses) ? misses : misses + SCORE_W'(1);
    assign busy       = (state == ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            led      <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            hits     <= '0;
            misses   <= '0;
            prev_idx <= '0;
            timer    <= '0;
            btn_q    <= '0;
        end else begin
            state    <= state_n;
            led      <= led_n;
            hit      <= hit_n;
            miss     <= miss_n;
            hits     <= hits_n;
            misses   <= misses_n;
            prev_idx <= prev_n;
            timer    <= timer_n;
            btn_q    <= btn;
        end
    end

    // Round judging order: clean target press, any other press, then timeout
    always_comb begin
        state_n  = state;
        led_n    = led;
        timer_n  = timer;
        prev_n   = prev_idx;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        hits_n   = hits;
        misses_n = misses;

        if (!enable) begin
            state_n = IDLE;
            led_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (spawn) begin
                        state_n = ACTIVE;
                        led_n   = NUM_TARGETS'(1) << idx;
                        prev_n  = idx;
                        timer_n = TW'(ON_CYCLES - 1);
                    end
                end
                ACTIVE: begin
                    if (btn_rise == led) begin
                        hit_n   = 1'b1;
                        hits_n  = hits_sat;
                        led_n   = '0;
                        state_n = IDLE;
                    end else if (btn_rise != '0 || timer == '0) begin
                        miss_n   = 1'b1;
                        misses_n = misses_sat;
                        led_n    = '0;
                        state_n  = IDLE;
                    end else begin
                        timer_n = timer - TW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    led_n   = '0;
                end
            endcase
        end

        if (clr_score) begin
            hits_n   = '0;
            misses_n = '0;
        end
    end

endmodule

// File: tb/tb_target_ctrl.sv
// Scoreboard bench for target_ctrl: stimulus queues expected LEDs and round
// results, a monitor process pops and compares whenever the DUT reports.
module tb_target_ctrl;

    localparam int NT  = 8;
    localparam int ONC = 10;
    localparam int SW  = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          enable    = 1'b0;
    logic          spawn     = 1'b0;
    logic          clr_score = 1'b0;
    logic [NT-1:0] btn       = '0;
    logic [NT-1:0] led;
    logic          hit, miss, busy;
    logic [SW-1:0] hits, misses;

    typedef struct packed {
        logic          is_hit;
        logic [SW-1:0] hits;
        logic [SW-1:0] misses;
    } res_t;

    res_t          exp_res[$];
    logic [NT-1:0] exp_led[$];
    int            tests_run = 0;
    int            fails     = 0;
    logic [SW-1:0] e_hits    = '0;
    logic [SW-1:0] e_misses  = '0;
    logic [15:0]   m_lfsr;
    logic [2:0]    m_prev    = '0;

    target_ctrl #(
        .NUM_TARGETS (NT),
        .ON_CYCLES   (ONC),
        .LFSR_SEED   (16'hACE1),
        .SCORE_W     (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .spawn     (spawn),
        .btn       (btn),
        .clr_score (clr_score),
        .led       (led),
        .hit       (hit),
        .miss      (miss),
        .hits      (hits),
        .misses    (misses),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference LFSR, x^16+x^14+x^13+x^11+1 in Galois form
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called on a negedge with the DUT idle; returns on the first lit cycle
    task automatic start_round(input logic hold, output logic [NT-1:0] l);
        logic [2:0] raw, idx;
        raw    = m_lfsr[2:0];
        idx    = (raw == m_prev) ? raw + 3'd1 : raw;
        m_prev = idx;
        l      = 8'b1 << idx;
        exp_led.push_back(l);
        spawn = 1'b1;
        if (hold) btn = l;
        tick();
        spawn = 1'b0;
    endtask

    task automatic expect_result(input logic is_hit, input logic clr);
        res_t r;
        if (clr) begin
            e_hits   = '0;
            e_misses = '0;
        end else if (is_hit) begin
            if (e_hits != 4'hF) e_hits = e_hits + 4'd1;
        end else begin
            if (e_misses != 4'hF) e_misses = e_misses + 4'd1;
        end
        r.is_hit = is_hit;
        r.hits   = e_hits;
        r.misses = e_misses;
        exp_res.push_back(r);
    endtask

    task automatic wait_result(input int budget, output int n);
        n = 0;
        while (!(hit || miss) && n < budget) begin
            tick();
            n++;
        end
        if (!(hit || miss)) check_output("result_timeout", 0, 1);
    endtask

    // Monitor: judge every pulse and every new round against the queues
    initial begin
        logic [NT-1:0] led_last;
        res_t          r;
        led_last = '0;
        forever begin
            @(negedge clk);
            if (hit && miss) check_output("hit_and_miss", 1, 0);
            if (hit || miss) begin
                if (exp_res.size() == 0) begin
                    check_output("unexpected_pulse", {hit, miss}, 0);
                end else begin
                    r = exp_res.pop_front();
                    check_output("result", {hit, hits, misses}, {r.is_hit, r.hits, r.misses});
                end
            end
            if (led != '0 && led_last == '0) begin
                if (exp_led.size() == 0) check_output("unexpected_led", led, 0);
                else check_output("led_target", led, exp_led.pop_front());
            end
            led_last = led;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NT-1:0] l, prev_l;
        int            n;

        tick();
        tick();
        check_output("rst_led",    led,    0);
        check_output("rst_pulses", {hit, miss}, 0);
        check_output("rst_hits",   hits,   0);
        check_output("rst_misses", misses, 0);
        check_output("rst_busy",   busy,   0);
        rst = 1'b0;
        tick();
        enable = 1'b1;
        tick();

        // Timeout: lit for exactly ONC cycles, then miss
        start_round(1'b0, l);
        expect_result(1'b0, 1'b0);
        for (int i = 0; i < ONC; i++) begin
            check_output("t1_led_lit", led, l);
            check_output("t1_busy", busy, 1);
            tick();
        end
        check_output("t1_miss", miss, 1);
        check_output("t1_led_off", led, 0);
        check_output("t1_busy_off", busy, 0);
        tick();
        check_output("t1_miss_once", miss, 0);

        // Correct press on the third lit cycle
        start_round(1'b0, l);
        expect_result(1'b1, 1'b0);
        tick();
        tick();
        btn = l;
        tick();
        check_output("t2_hit", hit, 1);
        check_output("t2_led_off", led, 0);
        btn = '0;
        tick();
        check_output("t2_hit_once", hit, 0);

        // Score clear, then wrong and combined presses
        clr_score = 1'b1;
        e_hits    = '0;
        e_misses  = '0;
        tick();
        clr_score = 1'b0;
        check_output("t3_clr", {hits, misses}, 0);
        start_round(1'b0, l);
        expect_result(1'b0, 1'b0);
        btn = {l[NT-2:0], l[NT-1]};
        tick();
        check_output("t3_wrong_miss", miss, 1);
        btn = '0;
        tick();
        start_round(1'b0, l);
        expect_result(1'b0, 1'b0);
        btn = l | {l[NT-2:0], l[NT-1]};
        tick();
        check_output("t3_combo_miss", miss, 1);
        check_output("t3_misses", misses, 2);
        btn = '0;
        tick();

        // Press on the last lit cycle still hits
        start_round(1'b0, l);
        expect_result(1'b1, 1'b0);
        repeat (ONC - 1) tick();
        check_output("t5_last_lit", led, l);
        btn = l;
        tick();
        check_output("t5_last_hit", hit, 1);
        btn = '0;
        tick();

        // Target held from round start never scores
        start_round(1'b1, l);
        expect_result(1'b0, 1'b0);
        wait_result(20, n);
        check_output("t4_held_len", n, ONC);
        btn = '0;
        tick();
        tick();

        // Spawn mid-round does not reload the timer
        start_round(1'b0, l);
        expect_result(1'b0, 1'b0);
        repeat (3) tick();
        spawn = 1'b1;
        tick();
        spawn = 1'b0;
        wait_result(20, n);
        check_output("t4_mid_spawn_len", n, ONC - 4);
        tick();
        check_output("t4_mid_spawn_idle", {busy, led}, 0);

        // Spawn in the resolving cycle is dropped
        start_round(1'b0, l);
        expect_result(1'b1, 1'b0);
        btn   = l;
        spawn = 1'b1;
        tick();
        spawn = 1'b0;
        btn   = '0;
        tick();
        check_output("t4_resolve_spawn", {busy, led}, 0);

        // Twenty back-to-back hits: no repeated target, hits saturate
        prev_l = l;
        for (int r = 0; r < 20; r++) begin
            start_round(1'b0, l);
            check_output("t4_no_repeat", (led == prev_l), 0);
            prev_l = l;
            expect_result(1'b1, 1'b0);
            btn = l;
            tick();
            btn = '0;
            tick();
        end
        check_output("t5_hits_sat", hits, 15);

        // Clear coincident with a hit
        start_round(1'b0, l);
        expect_result(1'b1, 1'b1);
        btn       = l;
        clr_score = 1'b1;
        tick();
        check_output("t5_clr_hit_pulse", hit, 1);
        check_output("t5_clr_hits", hits, 0);
        btn       = '0;
        clr_score = 1'b0;
        tick();

        // Enable dropped mid-round
        start_round(1'b0, l);
        tick();
        tick();
        enable = 1'b0;
        tick();
        check_output("t6_abort_led", led, 0);
        check_output("t6_abort_busy", busy, 0);
        check_output("t6_abort_pulse", {hit, miss}, 0);
        check_output("t6_abort_counts", {hits, misses}, {e_hits, e_misses});
        repeat (ONC + 2) tick();
        enable = 1'b1;
        tick();

        // Asynchronous reset between clock edges
        clr_score = 1'b0;
        start_round(1'b0, l);
        expect_result(1'b0, 1'b0);
        wait_result(20, n);
        tick();
        start_round(1'b0, l);
        tick();
        #2 rst = 1'b1;
        #1;
        check_output("t6_rst_led", led, 0);
        check_output("t6_rst_busy", busy, 0);
        check_output("t6_rst_counts", {hits, misses}, 0);
        tick();
        rst      = 1'b0;
        m_prev   = '0;
        e_hits   = '0;
        e_misses = '0;
        tick();
        start_round(1'b0, l);
        expect_result(1'b0, 1'b0);
        wait_result(20, n);
        check_output("t6_post_rst_len", n, ONC);
        repeat (3) tick();

        check_output("pending_results", exp_res.size(), 0);
        check_output("pending_leds", exp_led.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
